// File: rtl/pu_sched_pkg.sv
// Shared types and index-entry decode helpers for the per-lane delta scheduler.
// Field helpers take the entry zero-extended to 32 bits so any configured width can reuse them.
package pu_sched_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH_IDX,
    ST_DECODE,
    ST_FETCH_DELTA,
    ST_APPLY,
    ST_EMIT,
    ST_DONE
  } sched_state_t;

  typedef enum logic [1:0] {
    IDX_TARGET,
    IDX_PAD,
    IDX_END
  } idx_kind_t;

  localparam logic        MARKER_FLAG = 1'b1;
  localparam logic [31:0] END_PAYLOAD = 32'd0;

  function automatic logic [31:0] idx_field(input logic [31:0] entry, input int lsb, input int width);
    logic [31:0] mask;
    mask = (32'd1 << width) - 32'd1;
    return (entry >> lsb) & mask;
  endfunction

  function automatic idx_kind_t idx_decode(input logic [31:0] entry, input int width);
    logic [31:0] flag;
    logic [31:0] payload;
    flag    = idx_field(entry, width - 1, 1);
    payload = idx_field(entry, 0, width - 1);
    if (flag[0] != MARKER_FLAG) return IDX_TARGET;
    else if (payload == END_PAYLOAD) return IDX_END;
    else return IDX_PAD;
  endfunction

endpackage

// File: rtl/pu_weight_accum.sv
// Running-weight register: loads the base weight, then adds 1<<exp at BIN_LEN+1 bits.
// ovf flags a carry-out or an exponent that cannot fit; the stored weight wraps.
module pu_weight_accum #(
  parameter int BIN_LEN   = 8,
  parameter int DELTA_LEN = 4
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 load,
  input  logic [BIN_LEN-1:0]   load_value,
  input  logic                 add,
  input  logic [DELTA_LEN-1:0] add_exp,
  output logic [BIN_LEN-1:0]   weight,
  output logic                 ovf
);

  localparam logic [BIN_LEN:0] STEP_ONE = (BIN_LEN + 1)'(1);

  logic [BIN_LEN:0] step;
  logic [BIN_LEN:0] sum;

  assign step = STEP_ONE << add_exp;
  assign sum  = {1'b0, weight} + step;
  assign ovf  = add && (sum[BIN_LEN] || (int'(add_exp) >= BIN_LEN));

  // NOTE: sequential state is written with <= only, so every register samples pre-edge values.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset)    weight <= '0;
    else if (load) weight <= load_value;
    else if (add)  weight <= sum[BIN_LEN-1:0];
  end

endmodule

// File: rtl/pu_delta_scheduler.sv
// Per-lane MAC command sequencer: rebuilds sorted weights from base + run-length deltas
// and issues one command per target index entry. Optional counters: PU_SCHED_STATS_EN.
module pu_delta_scheduler
  import pu_sched_pkg::*;
#(
  parameter int BIN_LEN       = 8,
  parameter int DELTA_LEN     = 4,
  parameter int DELTA_SIM_LEN = 6,
  parameter int DELTA_NUM     = 64,
  parameter int INDEX_NUM     = 128,
  parameter int OC_LOG        = 3,
  parameter int KH_LOG        = 2,
  parameter int KW_LOG        = 2,
  parameter int INDEX_WIDTH   = OC_LOG + KH_LOG + KW_LOG + 1
) (
  input  logic                               clock,
  input  logic                               reset,
  input  logic                               start,
  input  logic [BIN_LEN-1:0]                 base_weight,
  output logic [$clog2(DELTA_NUM)-1:0]       delta_rd_addr,
  input  logic [DELTA_LEN+DELTA_SIM_LEN-1:0] delta_rd_data,
  output logic [$clog2(INDEX_NUM)-1:0]       idx_rd_addr,
  input  logic [INDEX_WIDTH-1:0]             idx_rd_data,
  output logic                               cmd_valid,
  input  logic                               cmd_ready,
  output logic [BIN_LEN-1:0]                 cmd_weight,
  output logic [OC_LOG-1:0]                  cmd_oc,
  output logic [KH_LOG-1:0]                  cmd_kh,
  output logic [KW_LOG-1:0]                  cmd_kw,
  output logic                               busy,
  output logic                               done,
  output logic                               err
`ifdef PU_SCHED_STATS_EN
  ,
  output logic [15:0]                        stat_cmds,
  output logic [15:0]                        stat_stall,
  output logic [7:0]                         stat_pads
`endif
);

  localparam int DADDR_W = $clog2(DELTA_NUM);
  localparam int IADDR_W = $clog2(INDEX_NUM);
  localparam logic [DADDR_W:0] DPTR_END = (DADDR_W + 1)'(DELTA_NUM);
  localparam logic [DADDR_W:0] DPTR_ONE = (DADDR_W + 1)'(1);
  localparam logic [IADDR_W:0] IPTR_END = (IADDR_W + 1)'(INDEX_NUM);
  localparam logic [IADDR_W:0] IPTR_ONE = (IADDR_W + 1)'(1);

  sched_state_t             state, state_nxt;
  logic [IADDR_W:0]         iptr;
  logic [DADDR_W:0]         dptr;
  logic                     first;
  logic [DELTA_SIM_LEN-1:0] remaining;
  logic [DELTA_SIM_LEN-1:0] delta_sim;
  logic [DELTA_LEN-1:0]     delta_val;
  idx_kind_t                idx_kind;
  logic                     accum_load, accum_add, accum_ovf;

  assign delta_val = delta_rd_data[DELTA_LEN-1:0];
  assign delta_sim = delta_rd_data[DELTA_LEN +: DELTA_SIM_LEN];
  assign idx_kind  = idx_decode(32'(idx_rd_data), INDEX_WIDTH);

  // Pointers are one bit wider than the buffers so "walked off the end" is visible.
  assign idx_rd_addr   = iptr[IADDR_W-1:0];
  assign delta_rd_addr = dptr[DADDR_W-1:0];

  assign cmd_valid = (state == ST_EMIT);
  assign done      = (state == ST_DONE);
  assign busy      = (state != ST_IDLE) && (state != ST_DONE);

  assign accum_load = (state == ST_IDLE) && start;
  assign accum_add  = (state == ST_APPLY) && (delta_sim != '0);

  pu_weight_accum #(
    .BIN_LEN   (BIN_LEN),
    .DELTA_LEN (DELTA_LEN)
  ) u_weight_accum (
    .clock      (clock),
    .reset      (reset),
    .load       (accum_load),
    .load_value (base_weight),
    .add        (accum_add),
    .add_exp    (delta_val),
    .weight     (cmd_weight),
    .ovf        (accum_ovf)
  );

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  // NOTE: the default at the top of an always_comb keeps every path assigned, so no latch appears.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:        if (start) state_nxt = ST_FETCH_IDX;
      ST_FETCH_IDX:   state_nxt = (iptr == IPTR_END) ? ST_DONE : ST_DECODE;
      ST_DECODE: begin
        case (idx_kind)
          IDX_END: state_nxt = ST_DONE;
          IDX_PAD: state_nxt = ST_FETCH_IDX;
          default: state_nxt = (first || remaining != '0) ? ST_EMIT : ST_FETCH_DELTA;
        endcase
      end
      ST_FETCH_DELTA: state_nxt = (dptr == DPTR_END) ? ST_DONE : ST_APPLY;
      ST_APPLY:       state_nxt = (delta_sim == '0) ? ST_FETCH_DELTA : ST_EMIT;
      ST_EMIT:        if (cmd_ready) state_nxt = ST_FETCH_IDX;
      ST_DONE:        state_nxt = ST_IDLE;
      default:        state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      iptr      <= '0;
      dptr      <= '0;
      first     <= 1'b0;
      remaining <= '0;
      err       <= 1'b0;
      cmd_oc    <= '0;
      cmd_kh    <= '0;
      cmd_kw    <= '0;
    end else begin
      case (state)
        ST_IDLE: if (start) begin
          iptr      <= '0;
          dptr      <= '0;
          first     <= 1'b1;
          remaining <= '0;
          err       <= 1'b0;
        end
        ST_FETCH_IDX: if (iptr == IPTR_END) err <= 1'b1;
        ST_DECODE: begin
          if (idx_kind == IDX_PAD) iptr <= iptr + IPTR_ONE;
          // Target latched here so EMIT stays stable whatever the index buffer does next.
          if (idx_kind == IDX_TARGET) begin
            cmd_oc <= OC_LOG'(idx_field(32'(idx_rd_data), KW_LOG + KH_LOG, OC_LOG));
            cmd_kh <= KH_LOG'(idx_field(32'(idx_rd_data), KW_LOG, KH_LOG));
            cmd_kw <= KW_LOG'(idx_field(32'(idx_rd_data), 0, KW_LOG));
          end
        end
        ST_FETCH_DELTA: if (dptr == DPTR_END) err <= 1'b1;
        ST_APPLY: begin
          dptr <= dptr + DPTR_ONE;
          if (delta_sim != '0) remaining <= delta_sim;
          if (accum_ovf) err <= 1'b1;
        end
        ST_EMIT: if (cmd_ready) begin
          iptr  <= iptr + IPTR_ONE;
          first <= 1'b0;
          if (!first) remaining <= remaining - DELTA_SIM_LEN'(1);
        end
        default: ;
      endcase
    end
  end

`ifdef PU_SCHED_STATS_EN
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      stat_cmds  <= '0;
      stat_stall <= '0;
      stat_pads  <= '0;
    end else if (state == ST_IDLE && start) begin
      stat_cmds  <= '0;
      stat_stall <= '0;
      stat_pads  <= '0;
    end else begin
      if (state == ST_EMIT && cmd_ready && stat_cmds != '1)   stat_cmds  <= stat_cmds + 16'd1;
      if (state == ST_EMIT && !cmd_ready && stat_stall != '1) stat_stall <= stat_stall + 16'd1;
      if (state == ST_DECODE && idx_kind == IDX_PAD && stat_pads != '1)
        stat_pads <= stat_pads + 8'd1;
    end
  end
`endif

endmodule

// File: doc/pu_delta_scheduler.md
# pu_delta_scheduler

Sequencer for one input-channel lane of `processing_unit`. On `start` it reconstructs the lane's sorted weights from a base weight plus a run-length delta list (`delta_vals`/`delta_sims`). It walks the index list and issues one MAC command per weight occurrence, each carrying the reconstructed weight and its `(output channel, kernel row, kernel col)` target, over a valid/ready handshake into the PU accumulation datapath. One instance sits per input channel, between the weight/index buffers and the PU multiplier array.

## Interface
- `BIN_LEN`, 8, weight / input bit width
- `DELTA_LEN`, 4, delta exponent width (delta = `1 << delta_val`)
- `DELTA_SIM_LEN`, 6, run-length width
- `DELTA_NUM`, 64, delta list depth
- `INDEX_NUM`, 128, index list depth
- `OC_LOG`, 3; `KH_LOG`, 2; `KW_LOG`, 2; target field widths
- `INDEX_WIDTH`, `OC_LOG+KH_LOG+KW_LOG+1`, index entry width; MSB is the marker flag
- `clock` in 1 — single clock, rising edge
- `reset` in 1 — asynchronous, active-low
- `start` in 1 — one-cycle pulse; ignored unless in IDLE
- `base_weight` in BIN_LEN — smallest sorted weight, sampled on `start`
- `delta_rd_addr` out clog2(DELTA_NUM) — delta buffer read address
- `delta_rd_data` in DELTA_LEN+DELTA_SIM_LEN — `{sim, val}`, valid one cycle after the address
- `idx_rd_addr` out clog2(INDEX_NUM) — index buffer read address
- `idx_rd_data` in INDEX_WIDTH — valid one cycle after the address
- `cmd_valid` out 1 — MAC command valid
- `cmd_ready` in 1 — datapath accepts the command
- `cmd_weight` out BIN_LEN — reconstructed weight
- `cmd_oc` out OC_LOG; `cmd_kh` out KH_LOG; `cmd_kw` out KW_LOG — target
- `busy` out 1 — high outside IDLE/DONE
- `done` out 1 — high for one cycle when the lane finishes
- `err` out 1 — sticky until next `start`: overflow or list exhaustion

## Operation
- Index entry decode:
  - MSB=0: target entry; consumes one weight occurrence.
  - MSB=1 with payload≠0: pad entry; skipped, nothing emitted.
  - MSB=1 with payload=0: end marker.
- Weight sequence:
  - The first target uses `base_weight`.
  - Each subsequent weight comes from the current delta entry `k`: on entering entry `k`, do `weight += 1 << val`, then emit `sim` targets at that weight.
  - `sim=0` means the entry is skipped, with no weight change.
- FSM states:
  - IDLE → FETCH_IDX on `start`. Clear the pointers and `err`; `weight = base_weight`; `first = 1`; `remaining = 0`.
  - FETCH_IDX: drive `idx_rd_addr = iptr`; go to DECODE.
  - DECODE:
    - End marker → DONE.
    - Pad → `iptr++`, FETCH_IDX.
    - Target with `first` or `remaining > 0` → EMIT.
    - Otherwise → FETCH_DELTA.
  - FETCH_DELTA: drive `delta_rd_addr = dptr`; go to APPLY. If `dptr == DELTA_NUM`, set `err` and go to DONE.
  - APPLY:
    - `sim=0` → `dptr++`, FETCH_DELTA.
    - Otherwise `weight += 1<<val`, `remaining = sim`, `dptr++`, EMIT.
  - EMIT: `cmd_valid = 1`, outputs held stable. On `cmd_ready`: `iptr++`; `remaining--` unless `first`; clear `first`; go to FETCH_IDX.
  - DONE: `done = 1` for one cycle, then IDLE.
- If `iptr` reaches `INDEX_NUM` without an end marker: set `err`, go to DONE.
- Weight arithmetic is done at BIN_LEN+1 bits. Set `err` on carry-out or on `val ≥ BIN_LEN`. The weight wraps modulo 2^BIN_LEN; the lane continues.
- `start` while busy is ignored.

## Timing
- Reset values: `cmd_valid=0`, `done=0`, `busy=0`, `err=0`, `cmd_*=0`, read addresses `0`, state IDLE.
- `start` to first `cmd_valid`: 3 cycles (FETCH_IDX, DECODE, EMIT).
- Steady state: with `cmd_ready` tied high, one command every 3 cycles. A delta-boundary command takes 5 cycles.
- `cmd_valid` never drops and `cmd_*` never change until the command is accepted.
- `done` asserts the cycle after the end marker is decoded. `busy` falls the same cycle.
- Reset asserted mid-run: immediately returns to IDLE and clears all outputs. Any command in flight is dropped.

## Configuration
- `PU_SCHED_STATS_EN`: when defined, adds output ports `stat_cmds` (16b, accepted commands), `stat_stall` (16b, cycles in EMIT with `cmd_ready=0`) and `stat_pads` (8b, pad entries skipped).
  - All three saturate at maximum, clear on `start`, and reset to 0.
- Without the macro, the ports and counters are absent; behaviour is otherwise identical.

## Structure
- Shared package `pu_sched_pkg`: FSM state enum, the index-entry field-extraction functions, and the pad/end-marker decode constants.
- Optional sub-module `pu_weight_accum`: the BIN_LEN+1 shift-add weight register with overflow detect. All else is inline.

## Test plan
- Base 3; deltas `{sim2,val1}`, `{sim1,val3}`; 4 targets then end marker → commands at weights 3, 5, 5, 13 with matching targets; `done` once; `err=0`.
- Pads interleaved (MSB=1, payload 5) between the targets above → identical command stream; `stat_pads=2` when `PU_SCHED_STATS_EN` is defined.
- Delta entry `{sim0,val2}` placed first → skipped; the weight after base 3 is 5 (from `val1`), not 9.
- `cmd_ready` low 4 cycles on the second command → `cmd_*` held stable throughout; `stat_stall=4`.
- BIN_LEN=8, base 250, delta `val3` → `err=1`; weight wraps to 2; the run completes with `done`.
- Reset pulsed while in EMIT → next cycle `cmd_valid=0`, `busy=0`; a fresh `start` reruns the first scenario correctly.
